// File: rtl/ext_mem_port_ctrl.sv
// External load/readback responder: turns held host strobes into single-cycle IRAM/DRAM accesses.
// Optional accepted-write counter on wr_count is enabled by defining EXT_WRITE_COUNT_EN.
module ext_mem_port_ctrl #(
  parameter int ADDR_W  = 9,
  parameter int DATA_W  = 16,
  parameter int N_CORES = 4,
  parameter int RD_LAT  = 1
) (
  input  logic               clock,
  input  logic               reset,
  input  logic               start,
  input  logic               start_2,
  input  logic               start_3,
  input  logic               start_4,
  input  logic [ADDR_W-1:0]  addr_ext,
  input  logic [DATA_W-1:0]  Data_in_ins,
  input  logic [DATA_W-1:0]  Data_in_dram,
  input  logic [N_CORES-1:0] iram_write_ext,
  input  logic               dram_write_ext,
  input  logic               read_en_ext,
  output logic [DATA_W-1:0]  dram_in_1,
  output logic [N_CORES-1:0] iram_we,
  output logic [ADDR_W-1:0]  mem_addr,
  output logic [DATA_W-1:0]  mem_wdata,
  output logic               dram_we,
  output logic               dram_re,
  input  logic [DATA_W-1:0]  dram_rdata,
  output logic               ext_owns_mem,
  output logic               core_run,
  output logic               proto_err,
  output logic [15:0]        wr_count
);

  typedef enum logic [2:0] {
    S_IDLE, S_RUN, S_LOAD_I, S_LOAD_D, S_RD_IDLE, S_RD_WAIT, S_RD_HOLD
  } state_t;

  // One cycle for the registered dram_re plus RD_LAT for the RAM, plus the capture cycle.
  localparam logic [2:0] CAP_CNT = 3'(RD_LAT + 1);
  localparam logic [N_CORES-1:0] ONE = {{(N_CORES-1){1'b0}}, 1'b1};

  state_t              state_q, state_d, tgt, rd_next;
  logic [N_CORES-1:0]  iw_q, iw_rise, iram_we_q, iram_we_d;
  logic                dw_q, rd_q, dw_rise, rd_rise;
  logic                dram_we_q, dram_we_d, dram_re_q, dram_re_d;
  logic [ADDR_W-1:0]   addr_q, addr_d;
  logic [DATA_W-1:0]   wdata_q, wdata_d, rdout_q, rdout_d;
  logic                perr_q, perr_d;
  logic [2:0]          cnt_q, cnt_d;
  logic [1:0]          sel_cnt;
  logic                st_is_rd;

  assign iw_rise  = iram_write_ext & ~iw_q;
  assign dw_rise  = dram_write_ext & ~dw_q;
  assign rd_rise  = read_en_ext & ~rd_q;
  assign sel_cnt  = {1'b0, start_2} + {1'b0, start_3} + {1'b0, start_4};
  assign st_is_rd = (state_q == S_RD_IDLE) || (state_q == S_RD_WAIT) || (state_q == S_RD_HOLD);

  always_comb begin
    state_d   = state_q;
    tgt       = S_IDLE;
    rd_next   = state_q;
    iram_we_d = '0;
    dram_we_d = 1'b0;
    dram_re_d = 1'b0;
    addr_d    = addr_q;
    wdata_d   = wdata_q;
    rdout_d   = rdout_q;
    perr_d    = perr_q;
    cnt_d     = cnt_q;

    if (start)                tgt = S_RUN;
    else if (sel_cnt > 2'd1) begin
      tgt    = S_IDLE;
      perr_d = 1'b1;
    end
    else if (start_2)         tgt = S_LOAD_I;
    else if (start_3)         tgt = S_LOAD_D;
    else if (start_4)         tgt = S_RD_IDLE;

    // Strobe edges act on the registered mode, so a mode change and an edge in the same cycle use the old mode.
    case (state_q)
      S_LOAD_I: begin
        if (iw_rise != '0) begin
          if ((iw_rise & (iw_rise - ONE)) == '0) begin
            iram_we_d = iw_rise;
            addr_d    = addr_ext;
            wdata_d   = Data_in_ins;
          end else begin
            perr_d = 1'b1;
          end
        end
      end
      S_LOAD_D: begin
        if (dw_rise) begin
          dram_we_d = 1'b1;
          addr_d    = addr_ext;
          wdata_d   = Data_in_dram;
        end
      end
      S_RD_IDLE, S_RD_HOLD: begin
        if (rd_rise) begin
          dram_re_d = 1'b1;
          addr_d    = addr_ext;
          cnt_d     = 3'd0;
          rd_next   = S_RD_WAIT;
        end else if (state_q == S_RD_HOLD && !read_en_ext) begin
          rd_next = S_RD_IDLE;
        end
      end
      S_RD_WAIT: begin
        if (rd_rise) perr_d = 1'b1;
        if (cnt_q == CAP_CNT) begin
          if (tgt == S_RD_IDLE) rdout_d = dram_rdata;
          rd_next = S_RD_HOLD;
        end else begin
          cnt_d = cnt_q + 3'd1;
        end
      end
      default: ;
    endcase

    if (tgt == S_RD_IDLE && st_is_rd) state_d = rd_next;
    else                              state_d = tgt;
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_q   <= S_IDLE;
      iw_q      <= '0;
      dw_q      <= 1'b0;
      rd_q      <= 1'b0;
      iram_we_q <= '0;
      dram_we_q <= 1'b0;
      dram_re_q <= 1'b0;
      addr_q    <= '0;
      wdata_q   <= '0;
      rdout_q   <= '0;
      perr_q    <= 1'b0;
      cnt_q     <= 3'd0;
    end else begin
      state_q   <= state_d;
      iw_q      <= iram_write_ext;
      dw_q      <= dram_write_ext;
      rd_q      <= read_en_ext;
      iram_we_q <= iram_we_d;
      dram_we_q <= dram_we_d;
      dram_re_q <= dram_re_d;
      addr_q    <= addr_d;
      wdata_q   <= wdata_d;
      rdout_q   <= rdout_d;
      perr_q    <= perr_d;
      cnt_q     <= cnt_d;
    end
  end

  assign iram_we      = iram_we_q;
  assign dram_we      = dram_we_q;
  assign dram_re      = dram_re_q;
  assign mem_addr     = addr_q;
  assign mem_wdata    = wdata_q;
  assign dram_in_1    = rdout_q;
  assign proto_err    = perr_q;
  assign core_run     = (state_q == S_RUN);
  assign ext_owns_mem = (state_q == S_LOAD_I) || (state_q == S_LOAD_D) || st_is_rd;

`ifdef EXT_WRITE_COUNT_EN
  logic [15:0] wcnt_q;
  logic        fire;

  assign fire = (iram_we_d != '0) || dram_we_d;

  // Entering LOAD_I restarts the count, but a write fired on that same edge still counts.
  always_ff @(posedge clock or posedge reset) begin
    if (reset)
      wcnt_q <= 16'd0;
    else if (state_d == S_LOAD_I && state_q != S_LOAD_I)
      wcnt_q <= {15'd0, fire};
    else if (fire && wcnt_q != 16'hFFFF)
      wcnt_q <= wcnt_q + 16'd1;
  end

  assign wr_count = wcnt_q;
`else
  assign wr_count = 16'd0;
`endif

endmodule

// File: tb/tb_ext_mem_port_ctrl.sv
// Scoreboard bench for ext_mem_port_ctrl: stimulus queues expected pulses, a negedge monitor checks them.
module tb_ext_mem_port_ctrl;
  localparam int AW = 9, DW = 16, NC = 4, RL = 2;
  localparam int K_IWE = 0, K_DWE = 1, K_DRE = 2, K_RD = 3;
`ifdef EXT_WRITE_COUNT_EN
  localparam int WC_ON = 1;
`else
  localparam int WC_ON = 0;
`endif

  logic          clock, reset, start, start_2, start_3, start_4;
  logic [AW-1:0] addr_ext, mem_addr;
  logic [DW-1:0] Data_in_ins, Data_in_dram, dram_in_1, mem_wdata, dram_rdata;
  logic [NC-1:0] iram_write_ext, iram_we;
  logic          dram_write_ext, read_en_ext, dram_we, dram_re;
  logic          ext_owns_mem, core_run, proto_err;
  logic [15:0]   wr_count;

  ext_mem_port_ctrl #(.ADDR_W(AW), .DATA_W(DW), .N_CORES(NC), .RD_LAT(RL)) dut (
    .clock(clock), .reset(reset), .start(start), .start_2(start_2), .start_3(start_3),
    .start_4(start_4), .addr_ext(addr_ext), .Data_in_ins(Data_in_ins),
    .Data_in_dram(Data_in_dram), .iram_write_ext(iram_write_ext),
    .dram_write_ext(dram_write_ext), .read_en_ext(read_en_ext), .dram_in_1(dram_in_1),
    .iram_we(iram_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata), .dram_we(dram_we),
    .dram_re(dram_re), .dram_rdata(dram_rdata), .ext_owns_mem(ext_owns_mem),
    .core_run(core_run), .proto_err(proto_err), .wr_count(wr_count)
  );

  typedef struct {
    int          kind;
    logic [3:0]  we;
    logic [8:0]  addr;
    logic [15:0] data;
    int          cyc;
  } ev_t;

  ev_t         exq[$];
  int          n_cmp = 0, n_err = 0, cyc = 0;
  logic [15:0] prev_rd = 16'h0;

  initial clock = 1'b0;
  always #5 clock = ~clock;
  always @(posedge clock) cyc <= cyc + 1;

  // DRAM model: read data appears RL clocks after the RAM samples dram_re, then holds.
  function automatic logic [15:0] ram_val(input logic [8:0] a);
    return (a == 9'd5) ? 16'h00AA : (16'h5500 | {7'h0, a});
  endfunction

  int         pend = 0;
  logic       act = 1'b0;
  logic [8:0] pa = 9'h0;
  initial dram_rdata = 16'h0;
  always @(posedge clock) begin
    if (dram_re) begin
      pend <= RL - 1;
      pa   <= mem_addr;
      act  <= 1'b1;
    end else if (act) begin
      if (pend == 0) begin
        dram_rdata <= ram_val(pa);
        act        <= 1'b0;
      end else begin
        pend <= pend - 1;
      end
    end
  end

  task automatic check_ev(input int k, input logic [3:0] w, input logic [8:0] a, input logic [15:0] d);
    ev_t e;
    n_cmp++;
    if (exq.size() == 0) begin
      n_err++;
      $display("FAIL unexpected_event: got kind=%0d we=%b addr=%0d data=%h cyc=%0d, required no event",
               k, w, a, d, cyc);
    end else begin
      e = exq.pop_front();
      if (e.kind != k || e.we != w || e.addr != a || e.data != d || e.cyc != cyc) begin
        n_err++;
        $display("FAIL event: got kind=%0d we=%b addr=%0d data=%h cyc=%0d, required kind=%0d we=%b addr=%0d data=%h cyc=%0d",
                 k, w, a, d, cyc, e.kind, e.we, e.addr, e.data, e.cyc);
      end
    end
  endtask

  always @(negedge clock) begin
    if (reset) begin
      prev_rd <= dram_in_1;
    end else begin
      if (iram_we != '0)        check_ev(K_IWE, iram_we, mem_addr, mem_wdata);
      if (dram_we)              check_ev(K_DWE, 4'b0, mem_addr, mem_wdata);
      if (dram_re)              check_ev(K_DRE, 4'b0, mem_addr, 16'h0);
      if (dram_in_1 != prev_rd) check_ev(K_RD, 4'b0, 9'h0, dram_in_1);
      prev_rd <= dram_in_1;
    end
  end

  task automatic tick(input int n);
    repeat (n) @(negedge clock);
  endtask

  task automatic expect_ev(input int k, input logic [3:0] w, input logic [8:0] a,
                           input logic [15:0] d, input int dc);
    ev_t e;
    e.kind = k; e.we = w; e.addr = a; e.data = d; e.cyc = cyc + dc;
    exq.push_back(e);
  endtask

  task automatic chk(input string name, input logic [31:0] act_v, input logic [31:0] exp_v);
    n_cmp++;
    if (act_v !== exp_v) begin
      n_err++;
      $display("FAIL %s: got %h, required %h", name, act_v, exp_v);
    end
  endtask

  initial begin
    reset = 1'b1; start = 0; start_2 = 1; start_3 = 0; start_4 = 0;
    addr_ext = '0; Data_in_ins = '0; Data_in_dram = '0;
    iram_write_ext = 4'b0001; dram_write_ext = 0; read_en_ext = 0;
    tick(2);
    chk("rst_iram_we", 32'(iram_we), 32'h0);
    chk("rst_ctl", {27'h0, dram_we, dram_re, ext_owns_mem, core_run, proto_err}, 32'h0);
    chk("rst_addr_data", {7'h0, mem_addr, mem_wdata}, 32'h0);
    chk("rst_dram_in_1", 32'(dram_in_1), 32'h0);
    chk("rst_wr_count", 32'(wr_count), 32'h0);

    // Strobe already high at release: must not fire.
    reset = 1'b0;
    tick(4);
    chk("owns_load_i", 32'(ext_owns_mem), 32'h1);
    chk("wr_count_after_rst", 32'(wr_count), 32'h0);
    iram_write_ext = 4'b0000;
    tick(2);

    // IRAM load: held strobe gives one pulse; data captured at the edge.
    addr_ext = 9'd1; Data_in_ins = 16'h1234;
    expect_ev(K_IWE, 4'b0010, 9'd1, 16'h1234, 1);
    iram_write_ext = 4'b0010;
    tick(1);
    addr_ext = 9'h77; Data_in_ins = 16'hFFFF;
    tick(3);
    iram_write_ext = 4'b0000;
    tick(2);
    chk("iram_addr_held", 32'(mem_addr), 32'h1);
    chk("wr_count_iram", 32'(wr_count), 32'(WC_ON));

    // DRAM load.
    start_2 = 0; start_3 = 1;
    tick(2);
    chk("owns_load_d", 32'(ext_owns_mem), 32'h1);
    for (int i = 0; i < 3; i++) begin
      addr_ext = 9'(i + 1); Data_in_dram = 16'((i + 1) * 10);
      expect_ev(K_DWE, 4'b0, 9'(i + 1), 16'((i + 1) * 10), 1);
      dram_write_ext = 1'b1;
      tick(1);
      addr_ext = 9'h1FF; Data_in_dram = 16'hDEAD;
      tick(2);
      dram_write_ext = 1'b0;
      tick(2);
    end
    // Wrong-mode strobes are ignored.
    iram_write_ext = 4'b0100; read_en_ext = 1'b1;
    tick(3);
    iram_write_ext = 4'b0000; read_en_ext = 1'b0;
    tick(1);
    chk("wr_count_dram", 32'(wr_count), 32'(4 * WC_ON));

    // Readback.
    start_3 = 0; start_4 = 1;
    tick(2);
    addr_ext = 9'd5;
    expect_ev(K_DRE, 4'b0, 9'd5, 16'h0, 1);
    expect_ev(K_RD, 4'b0, 9'h0, 16'h00AA, 1 + RL + 2);
    read_en_ext = 1'b1;
    tick(1);
    addr_ext = 9'd0;
    tick(6);
    chk("rd_data", 32'(dram_in_1), 32'h00AA);
    read_en_ext = 1'b0;
    tick(3);
    chk("rd_hold", 32'(dram_in_1), 32'h00AA);

    addr_ext = 9'd7;
    expect_ev(K_DRE, 4'b0, 9'd7, 16'h0, 1);
    expect_ev(K_RD, 4'b0, 9'h0, 16'h5507, 1 + RL + 2);
    read_en_ext = 1'b1;
    tick(7);
    read_en_ext = 1'b0;
    tick(2);

    // Leaving READ mid-access abandons the capture.
    addr_ext = 9'd5;
    expect_ev(K_DRE, 4'b0, 9'd5, 16'h0, 1);
    read_en_ext = 1'b1;
    tick(2);
    start_4 = 0;
    tick(6);
    chk("abandon_keep", 32'(dram_in_1), 32'h5507);
    chk("idle_not_owned", 32'(ext_owns_mem), 32'h0);
    read_en_ext = 1'b0;
    tick(2);
    chk("no_err_yet", 32'(proto_err), 32'h0);

    // Run handover: start wins over start_3; DRAM strobe ignored.
    start_3 = 1; start = 1;
    tick(2);
    chk("run_core_run", 32'(core_run), 32'h1);
    chk("run_not_owned", 32'(ext_owns_mem), 32'h0);
    dram_write_ext = 1'b1;
    tick(3);
    dram_write_ext = 1'b0;
    tick(2);
    chk("run_no_err", 32'(proto_err), 32'h0);
    start = 0; start_3 = 0;
    tick(2);

    // Conflicting mode lines.
    start_2 = 1; start_3 = 1;
    tick(2);
    chk("conflict_not_owned", 32'(ext_owns_mem), 32'h0);
    chk("conflict_perr", 32'(proto_err), 32'h1);
    reset = 1'b1;
    tick(2);
    chk("perr_cleared", 32'(proto_err), 32'h0);
    start_3 = 0;
    reset = 1'b0;
    tick(3);

    // Two IRAM strobes rising together.
    iram_write_ext = 4'b0011;
    tick(3);
    chk("multi_perr", 32'(proto_err), 32'h1);
    iram_write_ext = 4'b0000;
    tick(5);

    n_cmp++;
    if (exq.size() != 0) begin
      n_err++;
      $display("FAIL queue_drain: got %0d pending events, required 0", exq.size());
    end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule

// File: doc/ext_mem_port_ctrl.md
Name: ext_mem_port_ctrl

Overview:
- Memory-side responder for the external load/readback protocol driven by the host bench or loader.
- Decodes the mode lines start / start_2 / start_3 / start_4.
- Converts multi-cycle-held strobes (iram_write_ext_N, dram_write_ext, read_en_ext) into single-cycle IRAM/DRAM accesses.
- Returns readback data on dram_in_1. Sits in top_control_4 between the external pins and the IRAM/DRAM port muxes.

Parameters:
- ADDR_W, 9: external address width.
- DATA_W, 16: data word width.
- N_CORES, 4: number of IRAM write strobes/cores.
- RD_LAT, 1: DRAM read latency in clocks, from dram_re to dram_rdata valid; legal range 1-3.

Ports:
- clock  in  1  system clock, rising edge.
- reset  in  1  asynchronous active-high reset.
- start  in  1  run mode: cores own memory.
- start_2  in  1  IRAM load mode.
- start_3  in  1  DRAM load mode.
- start_4  in  1  DRAM readback mode.
- addr_ext  in  ADDR_W  external word address.
- Data_in_ins  in  DATA_W  instruction word to write.
- Data_in_dram  in  DATA_W  data word to write.
- iram_write_ext  in  N_CORES  per-core IRAM write strobes (level, held several cycles).
- dram_write_ext  in  1  DRAM write strobe (level).
- read_en_ext  in  1  DRAM read strobe (level).
- dram_in_1  out  DATA_W  readback word.
- iram_we  out  N_CORES  one-cycle IRAM write enables.
- mem_addr  out  ADDR_W  registered address to IRAM/DRAM.
- mem_wdata  out  DATA_W  registered write data.
- dram_we  out  1  one-cycle DRAM write enable.
- dram_re  out  1  one-cycle DRAM read enable.
- dram_rdata  in  DATA_W  DRAM read data.
- ext_owns_mem  out  1  high when external port muxes select this block.
- core_run  out  1  registered core enable.
- proto_err  out  1  sticky protocol error.
- wr_count  out  16  accepted-write counter (optional feature).

Behaviour:
- Reset:
  - All outputs 0. dram_in_1 = 0.
  - State IDLE. Strobe history registers = 0.
  - Reset mid-operation aborts any pending access. No enable is issued in the reset-release cycle.
- Mode decode, registered each cycle:
  - Exactly one of start_2 / start_3 / start_4 high -> LOAD_I / LOAD_D / READ respectively.
  - start high takes priority -> RUN.
  - None high -> IDLE.
  - Two or more of start_2/3/4 high with start low -> IDLE, and proto_err set.
- ext_owns_mem = 1 in LOAD_I, LOAD_D and READ-family states. core_run = 1 only in RUN.
- Edge detection: each strobe is registered. An access fires on a 0->1 transition only; a strobe held high for any duration yields exactly one access.
- LOAD_I:
  - Rising edge on iram_write_ext[k] -> next cycle iram_we[k] = 1 for one cycle; mem_addr/mem_wdata capture addr_ext/Data_in_ins at the edge.
  - More than one bit rising in the same cycle -> no write, proto_err set.
- LOAD_D:
  - Rising dram_write_ext -> dram_we pulse one cycle with Data_in_dram.
- READ, states RD_IDLE -> RD_WAIT -> RD_HOLD:
  - Rising read_en_ext -> dram_re pulse with the captured address, enter RD_WAIT.
  - After RD_LAT cycles, capture dram_rdata into dram_in_1 and go to RD_HOLD.
  - dram_in_1 holds until the next capture. Data is valid RD_LAT+2 clocks after the strobe edge.
  - Falling read_en_ext returns to RD_IDLE.
  - A new rising edge while in RD_WAIT is ignored and sets proto_err.
- Strobes for the wrong mode are ignored (no enable pulse).
- A strobe edge coinciding with a mode change is evaluated against the registered mode (old mode).
- Leaving a mode mid-read abandons the capture; dram_in_1 keeps its old value.
- addr_ext wraps naturally at ADDR_W; no range check.
- proto_err clears only on reset.

Optional Feature:
- Macro EXT_WRITE_COUNT_EN.
- Defined: wr_count increments by 1 on every iram_we or dram_we pulse. It saturates at 0xFFFF, clears on reset, and clears on entry to LOAD_I from another state.
- Undefined: wr_count tied to 0 and no counter logic is present.

Test Plan:
- Reset: with start_2=1 and iram_write_ext=4'b0001 already high at reset release -> no iram_we pulse; all outputs 0.
- IRAM load: start_2=1, addr_ext=1, Data_in_ins=16'h1234, iram_write_ext[1] held high 4 cycles -> exactly one iram_we=4'b0010 pulse with mem_addr=1, mem_wdata=16'h1234; wr_count=1 with macro.
- DRAM load: start_3=1, 3 strobes at addr 1,2,3 with data 10,20,30 -> three single dram_we pulses with matching address/data; an iram strobe in this mode gives no iram_we.
- Readback: start_4=1, addr_ext=5, dram_rdata model returns 16'h00AA, RD_LAT=2 -> single dram_re, dram_in_1=16'h00AA 4 clocks after the edge and stable until the next read.
- Protocol errors: start_2=start_3=1 -> ext_owns_mem=0 and proto_err=1. Separately, iram_write_ext=4'b0011 rising together -> no write and proto_err=1.
- Run handover: start=1 while start_3=1 -> core_run=1, ext_owns_mem=0; a dram_write_ext edge gives no dram_we.
